// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module  : alu_arb_pkg
// Brief   : Shared types, sizes and ALU function codes for the ALU arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDX_W    = $clog2(NREQ_DEF);

  typedef logic [IDX_W-1:0] req_idx_t;

  // ALU function codes, same encoding as alucodes.sv
  localparam logic [1:0] RA   = 2'd0;
  localparam logic [1:0] RADD = 2'd1;
  localparam logic [1:0] RSUB = 2'd2;
  localparam logic [1:0] RMUL = 2'd3;

  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module  : alu
// Brief   : N-bit fixed-point ALU: pass A, add, subtract, Q1.(N-1) multiply.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
  import alu_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [1:0]   func_i,
  output logic [N-1:0] result_o,
  output logic         zflag_o
);

  logic signed [2*N-1:0] w_prod;
  logic        [N-1:0]   w_mul;

  assign w_prod = (2*N)'($signed(a_i)) * (2*N)'($signed(b_i));
  // Q1.(N-1) * Q1.(N-1) -> keep product[2N-2:N-1]
  assign w_mul  = N'(w_prod >>> (N-1));

  always_comb begin
    result_o = a_i;
    case (func_i)
      RA:      result_o = a_i;
      RADD:    result_o = a_i + b_i;
      RSUB:    result_o = a_i - b_i;
      RMUL:    result_o = w_mul;
      default: result_o = a_i;
    endcase
  end

  assign zflag_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first request at or above ptr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one ALU among NREQ requesters, 1-cycle
//           latency. Define ALU_ARB_LOCK_EN to add the lock_i priority hold.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*N-1:0]   op_a_i,
  input  logic [NREQ*N-1:0]   op_b_i,
  input  logic [NREQ*2-1:0]   func_i,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]     lock_i,
`endif
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [N-1:0]        rsp_result_o,
  output logic                rsp_flag_o
);

  localparam int IW = idx_width(NREQ);

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [1:0]      w_func;
  logic [N-1:0]    w_res;
  logic            w_z;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rsp_valid_q;
  logic [N-1:0]    rsp_result_q;
  logic            rsp_flag_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (w_gnt),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  assign gnt_o = reset_i ? '0 : w_gnt;

  // With no request w_idx is 0, so slice 0 drives the (unused) ALU inputs
  assign w_a    = op_a_i[int'(w_idx)*N +: N];
  assign w_b    = op_b_i[int'(w_idx)*N +: N];
  assign w_func = func_i[int'(w_idx)*2 +: 2];

  alu #(
    .N (N)
  ) u_alu (
    .a_i      (w_a),
    .b_i      (w_b),
    .func_i   (w_func),
    .result_o (w_res),
    .zflag_o  (w_z)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (w_any) begin
      if (int'(w_idx) == NREQ-1) ptr_d = '0;
      else                       ptr_d = w_idx + 1'b1;
`ifdef ALU_ARB_LOCK_EN
      if (lock_i[w_idx]) ptr_d = w_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ptr_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= w_gnt;
      if (w_any) begin
        rsp_result_q <= w_res;
        rsp_flag_q   <= w_z;
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flag_o   = rsp_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Self-checking bench for alu_arbiter (scoreboard of responses).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 8;
  localparam int NR = 4;

  logic            clk     = 1'b0;
  logic            reset_i = 1'b1;
  logic [NR-1:0]   req_i   = '0;
  logic [NR*N-1:0] op_a_i  = '0;
  logic [NR*N-1:0] op_b_i  = '0;
  logic [NR*2-1:0] func_i  = '0;
`ifdef ALU_ARB_LOCK_EN
  logic [NR-1:0]   lock_i  = '0;
`endif
  logic [NR-1:0]   gnt_o;
  logic [NR-1:0]   rsp_valid_o;
  logic [N-1:0]    rsp_result_o;
  logic            rsp_flag_o;

  alu_arbiter #(.N(N), .NREQ(NR)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .func_i       (func_i),
`ifdef ALU_ARB_LOCK_EN
    .lock_i       (lock_i),
`endif
    .gnt_o        (gnt_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_result_o (rsp_result_o),
    .rsp_flag_o   (rsp_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] vld;
    logic [N-1:0]  res;
    logic          flag;
  } rsp_t;

  rsp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [N-1:0] last_res  = '0;
  logic         last_flag = 1'b0;

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [1:0] f);
    logic [N-1:0] r;
    int           sa, sb;
    logic [31:0]  p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = 32'(sa * sb);
    case (f)
      RA:      r = a;
      RADD:    r = a + b;
      RSUB:    r = a - b;
      default: r = p[14:7];
    endcase
    return {(r == '0), r};
  endfunction

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [1:0] f);
    op_a_i[i*N +: N] = a;
    op_b_i[i*N +: N] = b;
    func_i[i*2 +: 2] = f;
  endtask

  task automatic push_exp(input int i);
    logic [N:0] m;
    rsp_t       e;
    m      = model(op_a_i[i*N +: N], op_b_i[i*N +: N], func_i[i*2 +: 2]);
    e.vld  = NR'(1) << i;
    e.res  = m[N-1:0];
    e.flag = m[N];
    sb_q.push_back(e);
  endtask

  // Response monitor: one expectation per clock edge
  initial begin
    rsp_t e;
    logic rst_s;
    forever begin
      @(posedge clk);
      rst_s = reset_i;
      #1;
      if (rst_s) begin
        sb_q.delete();
        e = '0;
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e.vld  = '0;
        e.res  = last_res;
        e.flag = last_flag;
      end
      n_cmp++;
      if ({rsp_valid_o, rsp_result_o, rsp_flag_o} !== e) begin
        n_err++;
        $display("FAIL rsp @%0t: got vld=%b res=%h z=%b, want vld=%b res=%h z=%b",
                 $time, rsp_valid_o, rsp_result_o, rsp_flag_o, e.vld, e.res, e.flag);
      end
      last_res  = e.res;
      last_flag = e.flag;
    end
  end

  task automatic test_reset;
    reset_i = 1'b1;
    req_i   = 4'b1111;
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if (gnt_o !== 4'b0000) begin
        n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt_o);
      end
    end
    @(negedge clk);
    reset_i = 1'b0;
    req_i   = '0;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0000) begin
      n_err++; $display("FAIL idle_gnt_after_reset: got %b want 0000", gnt_o);
    end
  endtask

  task automatic test_single_add;
    @(negedge clk);
    set_op(0, 8'h05, 8'h03, RADD);
    req_i = 4'b0001;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL add_gnt: got %b want 0001", gnt_o);
    end
    push_exp(0);
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid_o, rsp_result_o, rsp_flag_o} !== {4'b0001, 8'h08, 1'b0}) begin
      n_err++; $display("FAIL add_rsp: got %b/%h/%b want 0001/08/0",
                        rsp_valid_o, rsp_result_o, rsp_flag_o);
    end
  endtask

  task automatic test_mul;
    @(negedge clk);
    set_op(2, 8'h40, 8'h40, RMUL);
    req_i = 4'b0100;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0100) begin
      n_err++; $display("FAIL mul_gnt: got %b want 0100", gnt_o);
    end
    push_exp(2);
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid_o, rsp_result_o} !== {4'b0100, 8'h20}) begin
      n_err++; $display("FAIL mul_rsp: got %b/%h want 0100/20", rsp_valid_o, rsp_result_o);
    end
  endtask

  task automatic test_zero_flag;
    @(negedge clk);
    set_op(1, 8'h05, 8'h05, RSUB);
    req_i = 4'b0010;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0010) begin
      n_err++; $display("FAIL zero_gnt: got %b want 0010", gnt_o);
    end
    push_exp(1);
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_result_o, rsp_flag_o} !== {8'h00, 1'b1}) begin
      n_err++; $display("FAIL zero_rsp: got %h/%b want 00/1", rsp_result_o, rsp_flag_o);
    end
  endtask

  // Pointer sits at 2 here; idling must not move it
  task automatic test_idle;
    req_i = '0;
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if (gnt_o !== 4'b0000) begin
        n_err++; $display("FAIL idle_gnt: got %b want 0000", gnt_o);
      end
    end
    @(negedge clk);
    set_op(3, 8'h7f, 8'h01, RADD);
    req_i = 4'b1011;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b1000) begin
      n_err++; $display("FAIL idle_ptr_hold: got %b want 1000", gnt_o);
    end
    push_exp(3);
  endtask

  task automatic test_back_to_back;
    logic [NR-1:0] exp_g[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int            exp_i[6] = '{0, 1, 2, 3, 0, 1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        set_op(i, N'($urandom), N'($urandom), 2'($urandom_range(3)));
      req_i = 4'b1111;
      #1;
      n_cmp++;
      if (gnt_o !== exp_g[c]) begin
        n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt_o, exp_g[c]);
      end
      push_exp(exp_i[c]);
    end
    @(negedge clk);
    req_i = '0;
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    set_op(3, 8'h11, 8'h22, RADD);
    req_i = 4'b1000;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b1000) begin
      n_err++; $display("FAIL midop_gnt: got %b want 1000", gnt_o);
    end
    push_exp(3);
    #1;
    reset_i = 1'b1;
    req_i   = '0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid_o, rsp_result_o} !== {4'b0000, 8'h00}) begin
      n_err++; $display("FAIL midop_discard: got %b/%h want 0000/00", rsp_valid_o, rsp_result_o);
    end
    reset_i = 1'b0;
    set_op(1, 8'h03, 8'h04, RADD);
    req_i = 4'b1010;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0010) begin
      n_err++; $display("FAIL midop_release_gnt: got %b want 0010", gnt_o);
    end
    push_exp(1);
    // Winner 0 would move ptr to 1; reset on this edge must return it to 0
    @(negedge clk);
    set_op(0, 8'h09, 8'h01, RSUB);
    req_i = 4'b0001;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL midop2_gnt: got %b want 0001", gnt_o);
    end
    push_exp(0);
    #1;
    reset_i = 1'b1;
    req_i   = '0;
    @(negedge clk);
    reset_i = 1'b0;
    req_i   = 4'b0011;
    #1;
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL midop2_ptr_reset: got %b want 0001", gnt_o);
    end
    push_exp(0);
    @(negedge clk);
    req_i = '0;
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock;
    logic [NR-1:0] exp_g[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    int            exp_i[5] = '{0, 0, 0, 0, 1};
    @(negedge clk);
    reset_i = 1'b1;
    req_i   = '0;
    @(negedge clk);
    reset_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      set_op(0, N'($urandom), N'($urandom), 2'($urandom_range(3)));
      set_op(1, N'($urandom), N'($urandom), 2'($urandom_range(3)));
      req_i  = 4'b0011;
      lock_i = (c < 3) ? 4'b0001 : 4'b0000;
      #1;
      n_cmp++;
      if (gnt_o !== exp_g[c]) begin
        n_err++; $display("FAIL lock_gnt[%0d]: got %b want %b", c, gnt_o, exp_g[c]);
      end
      push_exp(exp_i[c]);
    end
    @(negedge clk);
    req_i  = '0;
    lock_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_mul();
    test_zero_flag();
    test_idle();
    test_back_to_back();
    test_reset_midop();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    req_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit fixed-point ALU core (`alu`) between NREQ requesters, such as the decoder's immediate path, the MAC loop and the I/O unit.
- Selects one requester per cycle, drives that requester's operands and function code into the ALU, and registers the result and Z flag.
- Returns the registered result to the winning requester with a one-cycle valid pulse.
- Provides one-op-per-cycle throughput and fixed 1-cycle latency.

Parameters:
- n, 8, ALU operand/result width (passed to `alu`).
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held with stable operands until granted.
- op_a  in  NREQ*n  packed operand A; slice i belongs to requester i.
- op_b  in  NREQ*n  packed operand B.
- func  in  NREQ*2  packed ALU function codes (RA/RADD/RSUB/RMUL from alucodes.sv).
- gnt  out  NREQ  one-hot grant; combinational from req and the priority pointer.
- rsp_valid  out  NREQ  one-hot; bit i high for one cycle when result i is on rsp_result.
- rsp_result  out  n  registered ALU result.
- rsp_flag  out  1  registered ALU Z flag.

Behaviour:
- Reset values: gnt=0 (forced low while reset=1), rsp_valid=0, rsp_result=0, rsp_flag=0, priority pointer ptr=0.
- Arbitration (cycle t):
  - Winner is the first i with req[i]=1, searching from ptr upward modulo NREQ.
  - gnt[winner]=1 in the same cycle; the winner's op_a/op_b/func slices are muxed into `alu`.
- Capture (edge ending cycle t): ALU result and flag go into rsp_result/rsp_flag; rsp_valid[winner]=1 during t+1; ptr <= (winner+1) mod NREQ.
- Latency: exactly 1 cycle, grant to rsp_valid.
- Back-to-back: a requester keeping req high is eligible again next cycle. With all NREQ requesting, grants rotate 0,1,2,3,0,...
- No request: gnt=0, ALU inputs driven from slice 0 (don't-care), ptr unchanged, rsp_valid=0 next cycle, rsp_result/rsp_flag hold their previous values.
- Handshake: operands are sampled only in the gnt cycle. The requester may change operands or drop req in the cycle after gnt. Deasserting req before gnt withdraws the request, with no side effects.
- Wrap-around: ptr wraps from NREQ-1 to 0. Winner index NREQ-1 sets ptr=0.
- Reset mid-operation: a result captured on the reset edge is discarded; rsp_valid=0 in the next cycle and ptr returns to 0.
- Arithmetic: unchanged from `alu`; RMUL returns product[14:7] (Q1.7), modulo 2^n on add/sub.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro defined:
  - Extra input `lock` (NREQ bits).
  - If the winner has lock[winner]=1 in its grant cycle, ptr <= winner instead of winner+1, so it keeps top priority for multi-op sequences such as a MAC chain.
  - A locked winner that drops req loses priority normally: the search starts at ptr, finds another requester, and the pointer advances past that one.
- Without the macro: no `lock` port; pure round robin.

Decomposition:
- Package `alu_arb_pkg`:
  - Default NREQ.
  - Index width localparam ($clog2(NREQ)).
  - Typedef for the requester index.
  - Function-code constants re-exported from alucodes.sv.
- Sub-module `rr_pick`: combinational round-robin picker (req, ptr -> one-hot gnt plus winner index), reusable for the future memory-port arbiter.
- `alu` is instantiated unchanged.

Test Plan:
- Reset then single requester: req=0001, op_a[0]=0x05, op_b[0]=0x03, func=RADD -> gnt=0001 same cycle; next cycle rsp_valid=0001, rsp_result=0x08, rsp_flag=0.
- Fixed-point multiply: requester 2, op_a=0x40, op_b=0x40, RMUL -> rsp_result=0x20 (0.5*0.5=0.25), rsp_valid=0100.
- Zero flag: requester 1, 0x05 RSUB 0x05 -> rsp_result=0x00, rsp_flag=1.
- Fairness and wrap: req=1111 held for 6 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010; rsp_valid is the same sequence delayed by 1 cycle.
- Idle and reset mid-op: grant requester 3, then assert reset on the capture edge -> rsp_valid=0, result=0, ptr=0. After release with req=1010, gnt=0010 first.
- Lock (ALU_ARB_LOCK_EN): req=0011, lock=0001 for 3 cycles -> gnt=0001,0001,0001. Then lock=0 -> gnt=0001 on that cycle, then 0010 next.
